// File: rtl/sw_out_arbiter.sv
// sw_out_arbiter: per-output-port packet arbiter for a 4-input switch.
// Round-robin grant from a rotating priority pointer. A grant is held until
// the owner transfers its eop beat.
// Optional stall watchdog: define SW_ARB_TIMEOUT_EN to revoke a grant after
// TIMEOUT_CYCLES consecutive stalled cycles.
//
// state | meaning
// IDLE  | no owner; arbitrate among req each cycle
// BUSY  | one input port owns the output until eop (or watchdog expiry)
`timescale 1ns/1ps
module sw_out_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] valid,
  input  logic [3:0] eop,
  input  logic       suspend,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       xfer,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] gnt_id_q, gnt_id_d;
  logic       timeout_q, timeout_d;
  logic       win_found;
  logic [1:0] win_id;
  logic       xfer_w;
  logic       expire;

  // Reject out-of-range watchdog settings at elaboration.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("sw_out_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  assign xfer_w = (state_q == BUSY) & valid[gnt_id_q] & ~suspend;

  // Round-robin search: first set req bit at or above ptr, wrapping 3->0.
  always_comb begin
    win_found = 1'b0;
    win_id    = ptr_q;
    for (int i = 0; i < 4; i++) begin
      if (!win_found && req[2'(ptr_q + 2'(i))]) begin
        win_found = 1'b1;
        win_id    = 2'(ptr_q + 2'(i));
      end
    end
  end

`ifdef SW_ARB_TIMEOUT_EN
  localparam logic [15:0] TC_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        stall;

  // A stall is an owned cycle with no beat offered and no back-pressure;
  // suspended cycles neither count nor clear.
  assign stall  = (state_q == BUSY) & ~valid[gnt_id_q] & ~suspend;
  assign expire = stall & (stall_cnt_q == TC_LAST);

  // Stall counter next value: idle keeps it zero so every grant starts fresh.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE || xfer_w || expire) begin
      stall_cnt_d = '0;
    end else if (stall) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end
`else
  assign expire = 1'b0;
`endif

  // Next-state and registered-output logic for the IDLE/BUSY FSM.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d  = BUSY;
          gnt_d    = 4'b0001 << win_id;
          gnt_id_d = win_id;
          ptr_d    = win_id + 2'd1;
        end
      end
      BUSY: begin
        if ((xfer_w && eop[gnt_id_q]) || expire) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          gnt_id_d  = 2'd0;
          timeout_d = expire;
        end
      end
      default: begin
        state_d  = IDLE;
        gnt_d    = 4'b0000;
        gnt_id_d = 2'd0;
      end
    endcase
  end

  // FSM state and output registers; reset drops any grant immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= 2'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = (state_q == BUSY);
  assign xfer    = xfer_w;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_sw_out_arbiter.sv
// tb_sw_out_arbiter: directed stimulus with a scoreboard monitor for
// sw_out_arbiter. Stimulus pushes per-cycle level expectations and grant
// events; the monitor pops and compares on every falling edge.
`timescale 1ns/1ps
module tb_sw_out_arbiter;

  logic       clk;
  logic       reset;
  logic [3:0] req, valid, eop;
  logic       suspend;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy, xfer, timeout;

  sw_out_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .valid   (valid),
    .eop     (eop),
    .suspend (suspend),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .xfer    (xfer),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] gid;
    logic       busy;
    logic       xfer;
    logic       tmo;
  } lvl_t;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] gid;
    int         gap;
  } gr_t;

  lvl_t lvl_q[$];
  gr_t  gr_q[$];
  int   checks = 0;
  int   errors = 0;
  logic done = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_lvl(input logic [3:0] g, input logic [1:0] id,
                         input logic b, input logic x, input logic t);
    lvl_t e;
    e = '{g, id, b, x, t};
    lvl_q.push_back(e);
  endtask

  task automatic exp_gr(input logic [3:0] g, input logic [1:0] id, input int gap);
    gr_t e;
    e = '{g, id, gap};
    gr_q.push_back(e);
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    lvl_t e;
    gr_t  g;
    logic busy_prev;
    int   idle_cnt;
    busy_prev = 1'b0;
    idle_cnt  = 0;
    forever begin
      @(negedge clk);
      if (lvl_q.size() > 0) begin
        e = lvl_q.pop_front();
        checks++;
        if ({gnt, gnt_id, busy, xfer, timeout} !== {e.gnt, e.gid, e.busy, e.xfer, e.tmo}) begin
          errors++;
          $display("FAIL level t=%0t got gnt=%b id=%0d busy=%b xfer=%b tmo=%b exp gnt=%b id=%0d busy=%b xfer=%b tmo=%b",
                   $time, gnt, gnt_id, busy, xfer, timeout, e.gnt, e.gid, e.busy, e.xfer, e.tmo);
        end
      end else if (timeout) begin
        checks++;
        errors++;
        $display("FAIL unexpected_timeout t=%0t got tmo=1 exp tmo=0", $time);
      end
      if (busy && !busy_prev) begin
        checks++;
        if (gr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_grant t=%0t got gnt=%b id=%0d exp none", $time, gnt, gnt_id);
        end else begin
          g = gr_q.pop_front();
          if (gnt !== g.gnt || gnt_id !== g.gid || (g.gap >= 0 && idle_cnt != g.gap)) begin
            errors++;
            $display("FAIL grant t=%0t got gnt=%b id=%0d gap=%0d exp gnt=%b id=%0d gap=%0d",
                     $time, gnt, gnt_id, idle_cnt, g.gnt, g.gid, g.gap);
          end
        end
      end
      if (busy) idle_cnt = 0;
      else      idle_cnt++;
      busy_prev = busy;
      if (done) begin
        checks++;
        if (gr_q.size() != 0 || lvl_q.size() != 0) begin
          errors++;
          $display("FAIL pending got grants=%0d levels=%0d exp 0 0", gr_q.size(), lvl_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog got no completion exp completion by 100us");
    $fatal(1, "tb_sw_out_arbiter timed out");
  end

  // Directed stimulus
  initial begin : stim
    int owners[5];
    owners = '{0, 1, 2, 3, 0};
    reset = 1'b0; req = 4'b0; valid = 4'b0; eop = 4'b0; suspend = 1'b0;
    step();
    req = 4'hF;
    exp_lvl(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0); step();
    exp_lvl(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0); step();

    // Full contention after reset: order 0,1,2,3,0 with 2-beat packets
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_gr(4'b0001 << owners[k], 2'(owners[k]), (k == 0) ? -1 : 1);
      exp_lvl(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0); step();
      valid = 4'b0001 << owners[k]; eop = 4'b0000;
      exp_lvl(4'b0001 << owners[k], 2'(owners[k]), 1'b1, 1'b1, 1'b0); step();
      eop = 4'b0001 << owners[k];
      exp_lvl(4'b0001 << owners[k], 2'(owners[k]), 1'b1, 1'b1, 1'b0); step();
      valid = 4'b0000; eop = 4'b0000;
      if (k == 4) req = 4'b0000;
    end

    // Single-beat packet, then ptr=3 search wraps to port 2; owner drops req
    req = 4'b0100;
    exp_gr(4'b0100, 2'd2, 1);
    exp_lvl(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0); step();
    valid = 4'b0100; eop = 4'b0100;
    exp_lvl(4'b0100, 2'd2, 1'b1, 1'b1, 1'b0); step();
    valid = 4'b0000; eop = 4'b0000;
    exp_gr(4'b0100, 2'd2, 1);
    exp_lvl(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0); step();
    req = 4'b0000;
    exp_lvl(4'b0100, 2'd2, 1'b1, 1'b0, 1'b0); step();
    req = 4'hF; valid = 4'b0100; eop = 4'b0100;
    exp_lvl(4'b0100, 2'd2, 1'b1, 1'b1, 1'b0); step();
    valid = 4'b0000; eop = 4'b0000;
    exp_gr(4'b1000, 2'd3, 1);
    exp_lvl(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0); step();

    // Non-owner valid/eop and unqualified eop are ignored
    valid = 4'hF; eop = 4'b0111;
    exp_lvl(4'b1000, 2'd3, 1'b1, 1'b1, 1'b0); step();
    valid = 4'b0000; eop = 4'b1000;
    exp_lvl(4'b1000, 2'd3, 1'b1, 1'b0, 1'b0); step();
    valid = 4'b0111; eop = 4'b0111;
    exp_lvl(4'b1000, 2'd3, 1'b1, 1'b0, 1'b0); step();
    valid = 4'b1000; eop = 4'b1000;
    exp_lvl(4'b1000, 2'd3, 1'b1, 1'b1, 1'b0); step();
    valid = 4'b0000; eop = 4'b0000; req = 4'b0001;
    exp_gr(4'b0001, 2'd0, 1);
    exp_lvl(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0); step();
    valid = 4'b0001; eop = 4'b1000;
    exp_lvl(4'b0001, 2'd0, 1'b1, 1'b1, 1'b0); step();
    valid = 4'b1001; eop = 4'b1000;
    exp_lvl(4'b0001, 2'd0, 1'b1, 1'b1, 1'b0); step();
    valid = 4'b0001; eop = 4'b0001;
    exp_lvl(4'b0001, 2'd0, 1'b1, 1'b1, 1'b0); step();

    // Suspend for 5 cycles with valid+eop on the owner
    valid = 4'b0000; eop = 4'b0000; req = 4'b0010;
    exp_gr(4'b0010, 2'd1, 1);
    exp_lvl(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0); step();
    valid = 4'b0010; eop = 4'b0010; suspend = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_lvl(4'b0010, 2'd1, 1'b1, 1'b0, 1'b0); step();
    end
    suspend = 1'b0;
    exp_lvl(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0); step();

    // Stalled owner port 2; port 3 waiting
    valid = 4'b0000; eop = 4'b0000; req = 4'b0100;
    exp_gr(4'b0100, 2'd2, 1);
    exp_lvl(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0); step();
    req = 4'b1100;
`ifdef SW_ARB_TIMEOUT_EN
    exp_lvl(4'b0100, 2'd2, 1'b1, 1'b0, 1'b0); step();
    exp_lvl(4'b0100, 2'd2, 1'b1, 1'b0, 1'b0); step();
    suspend = 1'b1;
    exp_lvl(4'b0100, 2'd2, 1'b1, 1'b0, 1'b0); step();
    suspend = 1'b0;
    exp_lvl(4'b0100, 2'd2, 1'b1, 1'b0, 1'b0); step();
    exp_lvl(4'b0100, 2'd2, 1'b1, 1'b0, 1'b0); step();
    exp_gr(4'b1000, 2'd3, 1);
    exp_lvl(4'b0000, 2'd0, 1'b0, 1'b0, 1'b1); step();
    for (int k = 0; k < 3; k++) begin
      exp_lvl(4'b1000, 2'd3, 1'b1, 1'b0, 1'b0); step();
    end
    valid = 4'b1000;
    exp_lvl(4'b1000, 2'd3, 1'b1, 1'b1, 1'b0); step();
    valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      exp_lvl(4'b1000, 2'd3, 1'b1, 1'b0, 1'b0); step();
    end
    valid = 4'b1000; eop = 4'b1000;
    exp_lvl(4'b1000, 2'd3, 1'b1, 1'b1, 1'b0); step();
`else
    for (int k = 0; k < 8; k++) begin
      exp_lvl(4'b0100, 2'd2, 1'b1, 1'b0, 1'b0); step();
    end
    valid = 4'b0100; eop = 4'b0100;
    exp_lvl(4'b0100, 2'd2, 1'b1, 1'b1, 1'b0); step();
    valid = 4'b0000; eop = 4'b0000;
    exp_gr(4'b1000, 2'd3, 1);
    exp_lvl(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0); step();
    valid = 4'b1000; eop = 4'b1000;
    exp_lvl(4'b1000, 2'd3, 1'b1, 1'b1, 1'b0); step();
`endif

    // Reset mid-packet after 3 beats, then re-grant from ptr=0
    valid = 4'b0000; eop = 4'b0000; req = 4'b0010;
    exp_gr(4'b0010, 2'd1, 1);
    exp_lvl(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0); step();
    valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      exp_lvl(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0); step();
    end
    #1 reset = 1'b0;
    exp_lvl(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0); step();
    valid = 4'b0000; req = 4'b0000;
    exp_lvl(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0); step();
    reset = 1'b1; req = 4'b1010;
    exp_gr(4'b0010, 2'd1, -1);
    exp_lvl(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0); step();
    valid = 4'b0010; eop = 4'b0010;
    exp_lvl(4'b0010, 2'd1, 1'b1, 1'b1, 1'b0); step();
    valid = 4'b0000; eop = 4'b0000; req = 4'b0000;
    exp_lvl(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    done = 1'b1;
  end

endmodule

// File: doc/sw_out_arbiter.md
SW_OUT_ARBITER -- requirements
Module: sw_out_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, number of consecutive stalled cycles before a grant is revoked (range 1..65535).
REQ-002 Port: clk  input  1  switch clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  4  bit i set means input port i has a packet for this output port.
REQ-005 Port: valid  input  4  bit i set means input port i presents a data beat this cycle.
REQ-006 Port: eop  input  4  bit i set means the beat from input port i is the last beat of its packet; qualified by valid[i].
REQ-007 Port: suspend  input  1  output port back-pressure; while high, no beat transfers.
REQ-008 Port: gnt  output  4  one-hot grant to the owning input port; all zeros when no owner.
REQ-009 Port: gnt_id  output  2  index of the granted port; 0 when gnt is zero.
REQ-010 Port: busy  output  1  high while in BUSY state.
REQ-011 Port: xfer  output  1  combinational: busy & valid[gnt_id] & ~suspend.
REQ-012 Port: timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-013 FSM states: IDLE and BUSY only; encoding is free.
REQ-014 IDLE with req != 0: select the first set req bit, searching upward from the priority pointer ptr and wrapping 3->0; next cycle state=BUSY, gnt/gnt_id registered to the winner.
REQ-015 IDLE with req == 0: hold IDLE, gnt=0, ptr unchanged.
REQ-016 On entry to BUSY, ptr = (winner + 1) mod 4, so each requester waits for at most 3 other packets.
REQ-017 BUSY: the grant is held regardless of changes on req, including deassertion of req by the owner.
REQ-018 BUSY: a transfer occurs when xfer=1; valid/eop of non-granted ports are ignored.
REQ-019 BUSY: xfer=1 with eop[gnt_id]=1 -> next cycle state=IDLE, gnt=0; re-arbitration takes one IDLE cycle, so there is exactly one dead cycle between packets.
REQ-020 A single-beat packet (valid and eop on the first granted cycle) completes in one BUSY cycle.
REQ-021 suspend=1 in BUSY: no transfer and no state change; eop is ignored during that cycle.
REQ-022 Multicast and broadcast replication is outside this block: each output port instantiates its own arbiter, and the source port holds its data until all of its target arbiters have granted it.

Reset
REQ-023 reset low: state=IDLE, ptr=0, gnt=0, gnt_id=0, busy=0, timeout=0, watchdog counter=0, all applied immediately without a clock edge.
REQ-024 reset asserted mid-packet: the grant is dropped at once; the partial packet is not flagged.
REQ-025 On reset release, the first arbitration occurs on the first rising edge after reset goes high.

Configuration
REQ-026 Macro SW_ARB_TIMEOUT_EN defined: a 16-bit stall counter clears on entering BUSY and on each transfer.
REQ-027 The counter increments on each BUSY cycle with valid[gnt_id]=0 and suspend=0, and holds its value while suspend=1.
REQ-028 Counter reaching TIMEOUT_CYCLES: next cycle state=IDLE, gnt=0, timeout pulses high for one cycle, and ptr keeps its advanced value.
REQ-029 Macro not defined: no counter is present, timeout is tied to 0, and a stalled grant is held indefinitely.

Verification
REQ-030 After reset, req=4'b1111 with each owner sending 2 beats (eop on the 2nd) -> grant order 0,1,2,3,0, with one dead cycle between packets.
REQ-031 req=4'b0100 and ptr=3 -> gnt=4'b0100 and gnt_id=2 one cycle later; ptr then becomes 3.
REQ-032 Port 1 granted, suspend high for 5 cycles with valid[1]=1 and eop[1]=1 -> xfer=0 and the grant is held throughout; the release occurs the cycle after suspend drops.
REQ-033 Port 0 granted with valid[0]=1 and eop[3]=1 (port 3 not granted) -> no release; release happens only on eop[0].
REQ-034 With SW_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4: grant to port 2, valid[2]=0 -> timeout pulses once after 4 stalled cycles, gnt=0, and the next winner is port 3 if requesting.
REQ-035 reset driven low mid-packet (port 1 granted, 3 beats sent) -> gnt=0 immediately; after release, req=4'b0010 is re-granted from ptr=0.
